// File: rtl/frame_mem_arbiter.sv
// Multi-bank, multi-client frame-buffer SRAM arbiter with rotating buffer mapping and tagged read return.
// Define FRAME_MEM_ARBITER_RR_EN for per-bank round-robin arbitration; otherwise the lowest client index wins.
module frame_mem_arbiter #(
    parameter int NUM_CLIENTS  = 4,
    parameter int NUM_BANKS    = 2,
    parameter int NUM_BUFS     = 4,
    parameter int READ_LATENCY = 2,
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 36,
    parameter int IMAGE_LENGTH = 153600
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          frame_flag,
    input  logic [NUM_CLIENTS-1:0]        req,
    input  logic [NUM_CLIENTS-1:0]        wr,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] wdata,
    output logic [NUM_CLIENTS-1:0]        grant,
    output logic [NUM_CLIENTS-1:0]        rvalid,
    output logic [NUM_CLIENTS*DATA_W-1:0] rdata,
    output logic [NUM_BANKS*ADDR_W-1:0]   mem_addr,
    output logic [NUM_BANKS*DATA_W-1:0]   mem_wdata,
    output logic [NUM_BANKS-1:0]          mem_wr,
    input  logic [NUM_BANKS*DATA_W-1:0]   mem_rdata,
    output logic [2:0]                    frame_idx
);
    localparam int CID_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    logic [2:0]                                     frame_idx_q, frame_idx_d;
    logic [NUM_BANKS-1:0][READ_LATENCY-1:0]         pv_q, pv_d;
    logic [NUM_BANKS-1:0][READ_LATENCY-1:0][CID_W-1:0] pc_q, pc_d;
    logic [NUM_CLIENTS*DATA_W-1:0]                  rdata_q, rdata_d;
    logic                                           found;
    int                                             c, b, ci;
`ifdef FRAME_MEM_ARBITER_RR_EN
    logic [NUM_BANKS-1:0][CID_W-1:0]                ptr_q, ptr_d;
`endif

    assign frame_idx = frame_idx_q;

    always_comb begin
        frame_idx_d = frame_idx_q;
        if (frame_flag)
            frame_idx_d = (frame_idx_q == 3'(NUM_BUFS - 1)) ? 3'd0 : frame_idx_q + 3'd1;
    end

    always_comb begin
        grant     = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr    = '0;
        pv_d      = '0;
        pc_d      = '0;
        found     = 1'b0;
        c         = 0;
        b         = 0;
`ifdef FRAME_MEM_ARBITER_RR_EN
        ptr_d     = ptr_q;
`endif
        for (int k = 0; k < NUM_BANKS; k++) begin
            for (int s = 1; s < READ_LATENCY; s++) begin
                pv_d[k][s] = pv_q[k][s-1];
                pc_d[k][s] = pc_q[k][s-1];
            end
            found = 1'b0;
            for (int j = 0; j < NUM_CLIENTS; j++) begin
`ifdef FRAME_MEM_ARBITER_RR_EN
                c = (int'(ptr_q[k]) + 1 + j) % NUM_CLIENTS;
`else
                c = j;
`endif
                // Each client owns exactly one buffer, so it can only ever win on one bank.
                b = (int'(frame_idx_q) + c) % NUM_BUFS;
                if (reset && !found && req[c] && ((b % NUM_BANKS) == k)) begin
                    found     = 1'b1;
                    grant[c]  = 1'b1;
                    mem_wr[k] = wr[c];
                    mem_addr[k*ADDR_W +: ADDR_W]  = ADDR_W'((b / NUM_BANKS) * IMAGE_LENGTH)
                                                  + addr[c*ADDR_W +: ADDR_W];
                    mem_wdata[k*DATA_W +: DATA_W] = wdata[c*DATA_W +: DATA_W];
                    if (!wr[c]) begin
                        pv_d[k][0] = 1'b1;
                        pc_d[k][0] = CID_W'(c);
                    end
`ifdef FRAME_MEM_ARBITER_RR_EN
                    ptr_d[k] = CID_W'(c);
`endif
                end
            end
        end
    end

    // The last pipeline stage lines up with the SRAM returning data, so it is passed straight
    // through in the pulse cycle and captured for holding afterwards.
    always_comb begin
        rvalid = '0;
        rdata  = rdata_q;
        ci     = 0;
        if (reset) begin
            for (int k = 0; k < NUM_BANKS; k++) begin
                if (pv_q[k][READ_LATENCY-1]) begin
                    ci = int'(pc_q[k][READ_LATENCY-1]);
                    rvalid[ci] = 1'b1;
                    rdata[ci*DATA_W +: DATA_W] = mem_rdata[k*DATA_W +: DATA_W];
                end
            end
        end
        rdata_d = rdata;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            frame_idx_q <= '0;
            pv_q        <= '0;
            rdata_q     <= '0;
`ifdef FRAME_MEM_ARBITER_RR_EN
            for (int k = 0; k < NUM_BANKS; k++)
                ptr_q[k] <= CID_W'(NUM_CLIENTS - 1);
`endif
        end else begin
            frame_idx_q <= frame_idx_d;
            pv_q        <= pv_d;
            rdata_q     <= rdata_d;
`ifdef FRAME_MEM_ARBITER_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
        pc_q <= pc_d;
    end
endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Directed self-checking bench for frame_mem_arbiter at default parameters.
module tb_frame_mem_arbiter;
    localparam int NC = 4;
    localparam int NB = 2;
    localparam int AW = 19;
    localparam int DW = 36;

    logic             clock;
    logic             reset;
    logic             frame_flag;
    logic [NC-1:0]    req;
    logic [NC-1:0]    wr;
    logic [NC*AW-1:0] addr;
    logic [NC*DW-1:0] wdata;
    logic [NC-1:0]    grant;
    logic [NC-1:0]    rvalid;
    logic [NC*DW-1:0] rdata;
    logic [NB*AW-1:0] mem_addr;
    logic [NB*DW-1:0] mem_wdata;
    logic [NB-1:0]    mem_wr;
    logic [NB*DW-1:0] mem_rdata;
    logic [2:0]       frame_idx;

    int checks = 0;
    int errors = 0;

    frame_mem_arbiter dut (
        .clock(clock), .reset(reset), .frame_flag(frame_flag),
        .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .grant(grant), .rvalid(rvalid), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .frame_idx(frame_idx)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_client(input int ci, input logic w, input int a, input logic [DW-1:0] d);
        req[ci] = 1'b1;
        wr[ci]  = w;
        addr[ci*AW +: AW]  = AW'(a);
        wdata[ci*DW +: DW] = d;
    endtask

    task automatic clr_all();
        req = '0;
        wr  = '0;
    endtask

    task automatic set_rd(input int k, input logic [DW-1:0] v);
        mem_rdata[k*DW +: DW] = v;
    endtask

    function automatic logic [63:0] baddr(input int k);
        return 64'(mem_addr[k*AW +: AW]);
    endfunction

    function automatic logic [63:0] bwdata(input int k);
        return 64'(mem_wdata[k*DW +: DW]);
    endfunction

    function automatic logic [63:0] crdata(input int ci);
        return 64'(rdata[ci*DW +: DW]);
    endfunction

    initial begin
        reset = 1'b0; frame_flag = 1'b0;
        req = '0; wr = '0; addr = '0; wdata = '0; mem_rdata = '0;

        // Reset: outputs idle even with a request pending
        tick(); tick();
        set_client(0, 1'b1, 5, 36'h55);
        settle();
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_mem_wr", 64'(mem_wr), 64'h0);
        chk("rst_mem_addr0", baddr(0), 64'h0);
        chk("rst_rvalid", 64'(rvalid), 64'h0);
        chk("rst_rdata", 64'(rdata[63:0]), 64'h0);
        chk("rst_frame_idx", 64'(frame_idx), 64'h0);
        clr_all();
        tick();
        reset = 1'b1;
        tick();

        // Test 1: clients 0 and 2 contend for bank 0
        set_client(0, 1'b0, 7, '0);
        set_client(2, 1'b0, 10, '0);
        settle();
        chk("t1_grant_c0", 64'(grant), 64'h1);
        chk("t1_addr_c0", baddr(0), 64'd7);
        chk("t1_mem_wr", 64'(mem_wr), 64'h0);
        chk("t1_bank1_idle", baddr(1), 64'h0);
        tick();
        req[0] = 1'b0;
        settle();
        chk("t1_grant_c2", 64'(grant), 64'h4);
        chk("t1_addr_c2", baddr(0), 64'd153610);
        chk("t1_rvalid_early", 64'(rvalid), 64'h0);
        tick();
        req[2] = 1'b0;
        set_rd(0, 36'hAAAA0001);
        settle();
        chk("t1_rvalid_c0", 64'(rvalid), 64'h1);
        chk("t1_rdata_c0", crdata(0), 64'hAAAA0001);
        chk("t1_grant_none", 64'(grant), 64'h0);
        tick();
        set_rd(0, 36'hBBBB0002);
        settle();
        chk("t1_rvalid_c2", 64'(rvalid), 64'h4);
        chk("t1_rdata_c2", crdata(2), 64'hBBBB0002);
        chk("t1_rdata_c0_held", crdata(0), 64'hAAAA0001);
        tick();
        chk("t1_rvalid_done", 64'(rvalid), 64'h0);

        // Test 2: client 1 reads bank 1
        set_client(1, 1'b0, 5, '0);
        settle();
        chk("t2_grant", 64'(grant), 64'h2);
        chk("t2_addr", baddr(1), 64'd5);
        tick();
        clr_all();
        set_rd(1, 36'h111);
        settle();
        chk("t2_rvalid_t1", 64'(rvalid), 64'h0);
        tick();
        set_rd(1, 36'h5A5A5);
        settle();
        chk("t2_rvalid_t2", 64'(rvalid), 64'h2);
        chk("t2_rdata", crdata(1), 64'h5A5A5);
        tick();
        set_rd(1, 36'hFFFF);
        settle();
        chk("t2_rvalid_t3", 64'(rvalid), 64'h0);
        chk("t2_rdata_held", crdata(1), 64'h5A5A5);

        // Test 3: rotate once, then client 0 writes into bank 1
        tick();
        frame_flag = 1'b1;
        settle();
        chk("t3_idx_old", 64'(frame_idx), 64'h0);
        tick();
        frame_flag = 1'b0;
        set_client(0, 1'b1, 3, 36'h123);
        settle();
        chk("t3_idx_new", 64'(frame_idx), 64'h1);
        chk("t3_grant", 64'(grant), 64'h1);
        chk("t3_mem_wr", 64'(mem_wr), 64'h2);
        chk("t3_addr_b1", baddr(1), 64'd3);
        chk("t3_wdata_b1", bwdata(1), 64'h123);
        chk("t3_addr_b0", baddr(0), 64'h0);
        chk("t3_wdata_b0", bwdata(0), 64'h0);
        tick();
        clr_all();
        settle();
        chk("t3_rvalid_t1", 64'(rvalid), 64'h0);
        tick();
        chk("t3_rvalid_t2", 64'(rvalid), 64'h0);

        // Rotate 1 -> 2 -> 3 -> 0
        frame_flag = 1'b1;
        tick(); tick(); tick();
        frame_flag = 1'b0;
        settle();
        chk("wrap_idx", 64'(frame_idx), 64'h0);

        // Test 4: client 3 read coincides with frame_flag
        set_client(3, 1'b0, 20, '0);
        frame_flag = 1'b1;
        settle();
        chk("t4_grant", 64'(grant), 64'h8);
        chk("t4_addr_b1", baddr(1), 64'd153620);
        tick();
        frame_flag = 1'b0;
        set_client(3, 1'b0, 4, '0);
        settle();
        chk("t4_idx", 64'(frame_idx), 64'h1);
        chk("t4_rvalid_t1", 64'(rvalid), 64'h0);
        chk("t4_remap_addr_b0", baddr(0), 64'd4);
        chk("t4_remap_grant", 64'(grant), 64'h8);
        tick();
        clr_all();
        set_rd(1, 36'hC3C3C);
        set_rd(0, 36'h44);
        settle();
        chk("t4_rvalid_t2", 64'(rvalid), 64'h8);
        chk("t4_rdata", crdata(3), 64'hC3C3C);
        tick();
        settle();
        chk("t4_remap_rvalid", 64'(rvalid), 64'h8);
        chk("t4_remap_rdata", crdata(3), 64'h44);
        tick();

        // Test 5: reset lands while a read is in flight
        set_client(0, 1'b0, 9, '0);
        settle();
        chk("t5_grant", 64'(grant), 64'h1);
        tick();
        clr_all();
        set_client(1, 1'b1, 2, 36'h77);
        reset = 1'b0;
        settle();
        chk("t5_rst_grant", 64'(grant), 64'h0);
        chk("t5_rst_mem_wr", 64'(mem_wr), 64'h0);
        chk("t5_rst_rvalid", 64'(rvalid), 64'h0);
        tick();
        reset = 1'b1;
        clr_all();
        settle();
        chk("t5_rvalid_t2", 64'(rvalid), 64'h0);
        chk("t5_rdata_c1", crdata(1), 64'h0);
        chk("t5_rdata_c3", crdata(3), 64'h0);
        chk("t5_idx", 64'(frame_idx), 64'h0);
        tick();
        chk("t5_rvalid_t3", 64'(rvalid), 64'h0);

        // Test 6: clients 0 and 2 keep requesting bank 0
        set_client(0, 1'b0, 1, '0);
        set_client(2, 1'b0, 2, '0);
        for (int n = 0; n < 4; n++) begin
            settle();
`ifdef FRAME_MEM_ARBITER_RR_EN
            chk($sformatf("t6_rr_grant%0d", n), 64'(grant), (n % 2 == 0) ? 64'h1 : 64'h4);
`else
            chk($sformatf("t6_fixed_grant%0d", n), 64'(grant), 64'h1);
`endif
            tick();
        end
        clr_all();
        tick(); tick(); tick();
        chk("end_rvalid", 64'(rvalid), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_mem_arbiter.md
Name: frame_mem_arbiter

Overview:
- Parametrised, multi-bank, multi-client SRAM arbiter for the frame-buffer path; generalises the fixed 4-client, 2-bank memory interface.
- Each client accesses one rotating frame buffer, addressed linearly within the image. The block maps that buffer to a bank and location, arbitrates per bank, and returns tagged read data after a fixed SRAM latency.
- Sits between the NTSC, VGA, filter and transform clients and the external ZBT banks instantiated in the top module.

Parameters:
- NUM_CLIENTS, 4, number of requesting clients (1..8).
- NUM_BANKS, 2, number of SRAM banks (1..4).
- NUM_BUFS, 4, number of frame buffers in rotation; must be a multiple of NUM_BANKS.
- READ_LATENCY, 2, cycles from a read grant to valid data on mem_rdata (1..4).
- ADDR_W, 19, SRAM address width.
- DATA_W, 36, SRAM word width.
- IMAGE_LENGTH, 153600, words per frame buffer.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- frame_flag  in  1  one-cycle pulse; rotates the buffer mapping.
- req  in  NUM_CLIENTS  per-client access request; held until granted.
- wr  in  NUM_CLIENTS  per-client write enable (1=write, 0=read).
- addr  in  NUM_CLIENTS*ADDR_W  per-client word offset within its buffer.
- wdata  in  NUM_CLIENTS*DATA_W  per-client write data.
- grant  out  NUM_CLIENTS  combinational; access issued this cycle.
- rvalid  out  NUM_CLIENTS  registered one-cycle pulse; read data valid.
- rdata  out  NUM_CLIENTS*DATA_W  per-client read data; held between pulses.
- mem_addr  out  NUM_BANKS*ADDR_W  per-bank address.
- mem_wdata  out  NUM_BANKS*DATA_W  per-bank write data.
- mem_wr  out  NUM_BANKS  per-bank write strobe.
- mem_rdata  in  NUM_BANKS*DATA_W  per-bank read data.
- frame_idx  out  3  current rotation index (debug).

Behaviour:
- Buffer mapping:
  - buf(i) = (frame_idx + i) mod NUM_BUFS.
  - bank(b) = b mod NUM_BANKS.
  - loc(b) = b / NUM_BANKS.
  - Bank address = loc*IMAGE_LENGTH + addr_i, truncated to ADDR_W.
- frame_idx:
  - Reset to 0.
  - On frame_flag, increments mod NUM_BUFS; the new value takes effect the following cycle.
  - Requests in the frame_flag cycle use the old mapping.
- Arbitration (per bank, every cycle):
  - Candidates are clients with req=1 and bank(buf(i)) equal to that bank.
  - Fixed priority: the lowest client index wins.
  - The winner gets grant=1. mem_addr, mem_wdata and mem_wr=wr_i are driven combinationally in the same cycle.
  - Losers get grant=0 and must hold their request.
- Idle bank: mem_addr=0, mem_wdata=0, mem_wr=0.
- A client never receives more than one grant per cycle.
- Writes: complete on grant; no rvalid is produced.
- Read pipeline (per bank):
  - A READ_LATENCY-deep shift register of {valid, client_id}.
  - A granted read enters at stage 0.
  - When an entry reaches the last stage: rdata_i is loaded from mem_rdata of that bank, and rvalid_i pulses for one cycle.
- In-flight reads are tagged with client_id, so they complete to the issuing client even if frame_flag occurs mid-flight.
- rdata_i retains its last value when rvalid_i=0.
- Back-to-back reads on the same bank each return in order, one per cycle.
- Reset (reset=0 sampled at a clock edge):
  - frame_idx=0.
  - Pipelines cleared; rvalid=0; rdata=0.
  - grant and mem_* are forced to idle values while reset=0, including mid-operation; pending reads are discarded.
- Requests with frame_flag and reset asserted together: reset wins.

Optional Feature:
- Macro: FRAME_MEM_ARBITER_RR_EN.
- When defined, each bank uses round-robin arbitration:
  - A per-bank last-winner pointer, reset to NUM_CLIENTS-1.
  - Priority starts at the client after the last winner.
  - The pointer updates only when a grant is issued.
- When undefined, fixed lowest-index priority applies as above.

Test Plan:
1. Defaults, frame 0. Clients 0 and 2 both read bank 0, addr 7 and addr 10 → cycle 0: grant=0001, mem_addr[bank0]=7. Cycle 1 (client 2 holds): grant=0100, mem_addr[bank0]=153610. rvalid0 at cycle 2, rvalid2 at cycle 3, each carrying the bank-0 data present that cycle.
2. Client 1 reads addr 5 → bank 1 addr 5 at cycle t; rvalid1 pulses at t+2 only, rdata1=mem_rdata[bank1] at t+2, and is held afterwards.
3. One frame_flag pulse, then client 0 writes addr 3 with data 0x123 → frame_idx=1; bank 1 receives mem_wr=1, addr=3, wdata=0x123; bank 0 stays idle; no rvalid.
4. Client 3 issues a read, frame_flag the same cycle → the read uses old buf 3 (bank 1, addr offset 153600); data returns to client 3 at +2 despite the remap.
5. Read granted, then reset=0 one cycle later → no rvalid pulse, rdata=0, frame_idx=0, all mem_wr=0.
6. With FRAME_MEM_ARBITER_RR_EN and clients 0 and 2 continuously requesting bank 0 → grants alternate 0,2,0,2 starting with client 0.
